// File: rtl/activation_lut_writer.sv
// rtl/activation_lut_writer.sv - breakpoint table loader and registered pair reader for LUT activations
//
// Purpose: a host streams 2^ADDR_W+1 signed breakpoints in over a valid/ready
// handshake; once the table is complete it serves one-cycle-latency reads
// returning table[a] and table[a+1] to the interpolator datapath.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   load_start        - one-cycle request to (re)load the whole table
//   in_valid/in_data  - breakpoint stream, ascending index order
//   in_ready          - stream accept (combinational: LOAD and no load_start)
//   busy              - registered, high while loading
//   load_done         - one-cycle pulse after the last breakpoint is accepted
//   table_valid       - table fully loaded and readable
//   rd_en/rd_address  - read request and index
//   rd_ack/rd_err     - read response strobe and "table was not valid" flag
//   rd_base/rd_next   - table[a] and table[a+1]; hold when no read is pending
module activation_lut_writer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              load_done,
    output logic              table_valid,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_address,
    output logic              rd_ack,
    output logic              rd_err,
    output logic [DATA_W-1:0] rd_base,
    output logic [DATA_W-1:0] rd_next
);

    localparam int DEPTH = (1 << ADDR_W) + 1;
    localparam logic [ADDR_W:0] LAST_WP = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W:0]   wp_q;
    logic [DATA_W-1:0] table_q [DEPTH];
    logic              busy_q;
    logic              load_done_q;
    logic              table_valid_q;
    logic              rd_ack_q;
    logic              rd_err_q;
    logic [DATA_W-1:0] rd_base_q;
    logic [DATA_W-1:0] rd_next_q;

    logic              handshake;
    logic [ADDR_W:0]   rd_idx;

    // A load_start in LOAD takes priority over the stream, so the restart
    // cycle never consumes a breakpoint.
    assign in_ready  = (state_q == LOAD) && !load_start;
    assign handshake = in_ready && in_valid;

    // One extra address bit so that address 2^ADDR_W-1 reaches the last entry.
    assign rd_idx = {1'b0, rd_address};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wp_q          <= '0;
            busy_q        <= 1'b0;
            load_done_q   <= 1'b0;
            table_valid_q <= 1'b0;
            rd_ack_q      <= 1'b0;
            rd_err_q      <= 1'b0;
            rd_base_q     <= '0;
            rd_next_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            load_done_q <= 1'b0;

            case (state_q)
                IDLE, READY: begin
                    if (load_start) begin
                        state_q       <= LOAD;
                        busy_q        <= 1'b1;
                        wp_q          <= '0;
                        table_valid_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        // Restart: previously written entries stay until overwritten.
                        wp_q <= '0;
                    end else if (handshake) begin
                        table_q[wp_q] <= in_data;
                        if (wp_q == LAST_WP) begin
                            state_q       <= READY;
                            busy_q        <= 1'b0;
                            table_valid_q <= 1'b1;
                            load_done_q   <= 1'b1;
                            wp_q          <= '0;
                        end else begin
                            wp_q <= wp_q + ONE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Reads sample the pre-edge table and table_valid, independent of state.
            rd_ack_q <= rd_en;
            if (rd_en) begin
                if (table_valid_q) begin
                    rd_err_q  <= 1'b0;
                    rd_base_q <= table_q[rd_idx];
                    rd_next_q <= table_q[rd_idx + ONE];
                end else begin
                    rd_err_q  <= 1'b1;
                    rd_base_q <= '0;
                    rd_next_q <= '0;
                end
            end else begin
                rd_err_q <= 1'b0;
            end
        end
    end

    assign busy        = busy_q;
    assign load_done   = load_done_q;
    assign table_valid = table_valid_q;
    assign rd_ack      = rd_ack_q;
    assign rd_err      = rd_err_q;
    assign rd_base     = rd_base_q;
    assign rd_next     = rd_next_q;

endmodule

// File: tb/tb_activation_lut_writer.sv
// tb/tb_activation_lut_writer.sv - randomized self-checking bench for activation_lut_writer
module tb_activation_lut_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       busy;
    logic       load_done;
    logic       table_valid;
    logic       rd_en = 1'b0;
    logic [3:0] rd_address = 4'h0;
    logic       rd_ack;
    logic       rd_err;
    logic [7:0] rd_base;
    logic [7:0] rd_next;

    activation_lut_writer #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .busy        (busy),
        .load_done   (load_done),
        .table_valid (table_valid),
        .rd_en       (rd_en),
        .rd_address  (rd_address),
        .rd_ack      (rd_ack),
        .rd_err      (rd_err),
        .rd_base     (rd_base),
        .rd_next     (rd_next)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_done_cyc = -1;
    int done_seen = 0;

    // Reference model: the table, how many breakpoints of the current load
    // have been taken, and whether a load is in progress / complete.
    logic [7:0] m_tab [17];
    bit         m_loading = 1'b0;
    bit         m_valid = 1'b0;
    int         m_cnt = 0;
    logic       m_ack = 1'b0, m_err = 1'b0, m_done = 1'b0;
    logic [7:0] m_base = 8'h00, m_next = 8'h00;

    logic [7:0] vals [17];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs after the falling edge, check in_ready before the
    // rising edge, advance the model, check registered outputs after the edge.
    task automatic step(input logic r, input logic ls, input logic iv, input logic [7:0] d,
                        input logic re, input logic [3:0] ra);
        rst = r; load_start = ls; in_valid = iv; in_data = d; rd_en = re; rd_address = ra;
        #1;
        chk("in_ready", in_ready, m_loading && !ls);
        if (r) begin
            foreach (m_tab[i]) m_tab[i] = 8'h00;
            m_loading = 0; m_valid = 0; m_cnt = 0;
            m_ack = 0; m_err = 0; m_done = 0; m_base = 0; m_next = 0;
        end else begin
            if (re) begin
                m_ack  = 1;
                m_err  = !m_valid;
                m_base = m_valid ? m_tab[int'(ra)]     : 8'h00;
                m_next = m_valid ? m_tab[int'(ra) + 1] : 8'h00;
            end else begin
                m_ack = 0;
                m_err = 0;
            end
            m_done = 0;
            if (ls) begin
                m_loading = 1; m_cnt = 0; m_valid = 0;
            end else if (m_loading && iv) begin
                m_tab[m_cnt] = d;
                m_cnt++;
                if (m_cnt == 17) begin
                    m_loading = 0; m_valid = 1; m_done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("busy",        busy,        m_loading);
        chk("load_done",   load_done,   m_done);
        chk("table_valid", table_valid, m_valid);
        chk("rd_ack",      rd_ack,      m_ack);
        chk("rd_err",      rd_err,      m_err);
        chk("rd_base",     rd_base,     m_base);
        chk("rd_next",     rd_next,     m_next);
        if (load_done === 1'b1) begin
            done_seen++;
            last_done_cyc = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    // Stream vals[] into the block, optionally with random in_valid gaps and
    // random concurrent reads. Bounded so a stuck DUT cannot hang the run.
    task automatic feed(input bit gaps, input int first);
        int idx = first;
        int guard = 0;
        logic iv;
        while (idx < 17 && guard < 200) begin
            iv = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            step(0, 0, iv, iv ? vals[idx] : 8'($urandom),
                 gaps ? 1'($urandom) : 1'b0, 4'($urandom));
            if (iv) idx++;
            guard++;
        end
        chk("feed_bound", guard < 200, 1);
    endtask

    task automatic rand_vals();
        foreach (vals[i]) vals[i] = 8'($urandom);
    endtask

    initial begin
        int start_cyc;
        @(negedge clk);

        // Reset and read before load.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4'd3);
        chk("pre_load_err", rd_err, 1);
        step(0, 0, 1, 8'h55, 0, 0);

        // Full contiguous load of a ramp; load_done in the 18th cycle.
        foreach (vals[i]) vals[i] = 8'(i * 8);
        vals[16] = 8'h7F;
        start_cyc = cyc;
        done_seen = 0;
        step(0, 1, 0, 0, 0, 0);
        feed(0, 0);
        chk("load_cycles", last_done_cyc - start_cyc + 1, 18);
        chk("load_done_once", done_seen, 1);
        step(0, 0, 0, 0, 1, 4'd15);
        chk("addr15_base", rd_base, 8'h78);
        chk("addr15_next", rd_next, 8'h7F);
        step(0, 0, 0, 0, 1, 4'd0);
        chk("addr0_next", rd_next, 8'h08);
        step(0, 0, 0, 0, 0, 0);

        // Backpressure gaps with signed corner values; back-to-back reads.
        rand_vals();
        vals[3] = 8'h80; vals[7] = 8'hFF; vals[16] = 8'h80;
        step(0, 1, 0, 0, 0, 0);
        feed(1, 0);
        for (int a = 0; a < 16; a++) step(0, 0, 0, 0, 1, 4'(a));
        step(0, 0, 0, 0, 0, 0);

        // Restart mid-load: 5 accepted, then load_start with in_valid high.
        rand_vals();
        done_seen = 0;
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'($urandom), 0, 0);
        step(0, 1, 1, 8'hEE, 0, 0);
        feed(0, 0);
        chk("restart_done_once", done_seen, 1);
        for (int a = 0; a < 16; a++) step(0, 0, 0, 0, 1, 4'(a));

        // Reload from READY with a read on the same edge, then read during LOAD.
        step(0, 1, 0, 0, 1, 4'd15);
        chk("reload_read_err", rd_err, 0);
        step(0, 0, 0, 0, 1, 4'd2);
        chk("load_read_err", rd_err, 1);
        rand_vals();
        feed(0, 0);

        // Reset mid-load after 9 writes, then a fresh load.
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 8'($urandom), 0, 0);
        step(1, 0, 1, 8'h11, 1, 4'd1);
        step(0, 0, 0, 0, 1, 4'd1);
        chk("post_reset_err", rd_err, 1);
        rand_vals();
        step(0, 1, 0, 0, 0, 0);
        feed(1, 0);
        for (int a = 0; a < 16; a++) step(0, 0, 0, 0, 1, 4'($urandom));

        // Unstructured random traffic, including occasional resets.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 150) == 0, $urandom_range(0, 30) == 0,
                 1'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/activation_lut_writer.md
# activation_lut_writer

Programmable breakpoint table for the LUT-plus-interpolation activation units. A host streams the 17 signed breakpoints of an activation curve (e.g. sigmoid) in over a valid/ready handshake. The block then serves registered table reads that return a base value and its successor (`next_data`) to the interpolator datapath. It is the write/serve side of the `address -> base, next_data` interface that the activation functions consume.

## Interface
- `DATA_W`, default 8: breakpoint width, signed two's complement.
- `ADDR_W`, default 4: read address width; the table holds 2^ADDR_W+1 entries (17 by default).
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `load_start` input 1: one-cycle request to (re)load the whole table.
- `in_valid` input 1: `in_data` holds a breakpoint.
- `in_data` input DATA_W: breakpoint value, written in ascending index order 0..2^ADDR_W.
- `in_ready` output 1: breakpoint accepted when `in_valid && in_ready` at the rising edge.
- `busy` output 1: high while in LOAD.
- `load_done` output 1: one-cycle pulse after the last breakpoint is accepted.
- `table_valid` output 1: table fully loaded and readable.
- `rd_en` input 1: read request.
- `rd_address` input ADDR_W: read index.
- `rd_ack` output 1: read response valid, exactly one cycle after `rd_en`.
- `rd_err` output 1: qualifies `rd_ack`; the read was made while the table was not valid.
- `rd_base` output DATA_W: table[rd_address].
- `rd_next` output DATA_W: table[rd_address+1].

## Operation
- States: IDLE, LOAD, READY.
- Reset:
  - State goes to IDLE and the write pointer `wp` to 0.
  - All 17 entries clear to 0.
  - All outputs go to 0, including `in_ready`, `busy`, `load_done`, `table_valid`, `rd_ack`, `rd_err`, `rd_base` and `rd_next`.
- IDLE: `load_start` moves to LOAD, sets `wp`=0 and `table_valid`=0.
- LOAD:
  - `in_ready = (state==LOAD) && !load_start`. This is the only combinational path from input to output.
  - Each handshake writes `table[wp] <= in_data` and increments `wp`.
  - A handshake at `wp`=2^ADDR_W moves to READY, sets `table_valid`=1 and pulses `load_done`.
  - `load_start` in LOAD restarts: `wp`=0 and no write that cycle. Entries already written are kept until they are overwritten.
  - `in_valid` with `in_ready` low is ignored; the data is neither written nor dropped silently from the host's view, because no handshake occurred.
- READY:
  - `load_start` moves to LOAD, clears `table_valid` and sets `wp`=0.
  - `in_valid` in READY or IDLE is ignored.
- Reads:
  - Reads are independent of state.
  - `rd_en` at edge N gives `rd_ack`=1 at edge N+1.
  - If `table_valid` was 1 at edge N: `rd_err`=0, `rd_base`=table[a], `rd_next`=table[a+1].
  - Otherwise: `rd_err`=1 and `rd_base`=`rd_next`=0.
  - `rd_address` is ADDR_W bits, so a+1 ≤ 2^ADDR_W and there is no wrap. Address 15 returns entries 15 and 16.
  - `rd_ack`/`rd_err` drop to 0 in any cycle following `rd_en`=0. `rd_base`/`rd_next` hold their last value.
- Same-edge collisions:
  - Read and `load_start` on the same edge: the read samples the pre-edge `table_valid`, so it returns data.
  - Read on the same edge as the final handshake: `rd_err`=1, because `table_valid` was still 0.
- Reset during LOAD or with a read pending: reset wins. No `rd_ack` or `load_done` is produced afterwards for requests made before reset.

## Timing
- Load takes 17 accepted handshakes. The minimum is 18 cycles from the `load_start` edge to `load_done` high, with `in_valid` held high.
- `load_done` is high exactly one cycle, in the cycle after the final handshake edge. `table_valid` rises in that same cycle.
- Read latency is 1 cycle, fully pipelined: back-to-back `rd_en` gives back-to-back `rd_ack`.
- `busy` equals (state==LOAD) and is registered.

## Test plan
- **Reset and read before load:** reset, then `rd_en` with address 3 -> next cycle `rd_ack`=1, `rd_err`=1, `rd_base`=`rd_next`=0; `table_valid`=0.
- **Full load, contiguous:** `load_start`, then values 0x00,0x08,…,0x78,0x7F streamed with `in_valid` held -> `load_done` pulses once 18 cycles after start. Read address 15 -> `rd_base`=0x78, `rd_next`=0x7F, `rd_err`=0. Read address 0 -> 0x00/0x08.
- **Backpressure gaps:** random `in_valid` gaps, signed values including 0x80 and 0xFF -> exactly 17 writes, order preserved. Read addresses 0..15 back-to-back -> 16 consecutive acks, each with correct pairs.
- **Restart mid-load:** 5 values accepted, then `load_start` pulsed while `in_valid`=1 -> `in_ready`=0 that cycle and no write. The reload of 17 new values fully replaces the table, and `load_done` pulses only once.
- **Reload from READY:**
  - Pulse `load_start` with `rd_en` on the same edge -> that read returns old data with `rd_err`=0.
  - `table_valid` then drops; a read during LOAD returns `rd_err`=1.
- **Reset mid-load:** `rst` after 9 writes -> all outputs 0 and state IDLE. A subsequent read returns `rd_err`=1, and a fresh load succeeds.
